// File: rtl/hack_alu_seq.sv
// Registered, handshaked Hack ALU with zr/ng flags and valid/ready flow control.
// Define HACK_ALU_MUL_EN to build the iterative shift-add multiply mode.
module hack_alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  input  logic             mul,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             busy
);

  logic [WIDTH-1:0] xa, xb, ya, yb;
  logic [WIDTH-1:0] alu_o, alu_res;
  logic             accept;
  logic             load;
  logic [WIDTH-1:0] load_val;

  logic [WIDTH-1:0] out_q, out_d;
  logic             zr_q, zr_d;
  logic             ng_q, ng_d;
  logic             out_valid_q, out_valid_d;

  always_comb begin
    xa      = zx ? '0 : x;
    xb      = nx ? ~xa : xa;
    ya      = zy ? '0 : y;
    yb      = ny ? ~ya : ya;
    alu_o   = f ? (xb + yb) : (xb & yb);
    alu_res = no ? ~alu_o : alu_o;
  end

`ifdef HACK_ALU_MUL_EN
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_step;

  assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign busy     = (state_q == MUL);
`else
  logic unused_mul;

  assign unused_mul = mul;
  assign in_ready   = !out_valid_q || out_ready;
  assign busy       = 1'b0;
`endif

  assign accept = in_valid && in_ready;

  always_comb begin
    out_d       = out_q;
    zr_d        = zr_q;
    ng_d        = ng_q;
    out_valid_d = out_valid_q && !out_ready;
    load        = 1'b0;
    load_val    = alu_res;
`ifdef HACK_ALU_MUL_EN
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (mul) begin
            state_d  = MUL;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = xb;
            mplier_d = yb;
          end else begin
            load = 1'b1;
          end
        end
      end
      MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // last iteration folds straight into the result register
        if (cnt_q == CW'(WIDTH - 1)) begin
          load     = 1'b1;
          load_val = acc_step;
          state_d  = IDLE;
          cnt_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase
`else
    if (accept) begin
      load = 1'b1;
    end
`endif
    if (load) begin
      out_d       = load_val;
      zr_d        = (load_val == '0);
      ng_d        = load_val[WIDTH-1];
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_q       <= '0;
      zr_q        <= 1'b0;
      ng_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      zr_q        <= zr_d;
      ng_q        <= ng_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef HACK_ALU_MUL_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end
`endif

  assign out       = out_q;
  assign zr        = zr_q;
  assign ng        = ng_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_hack_alu_seq.sv
// Directed bench for hack_alu_seq (WIDTH=16).
// Multiply scenarios run when HACK_ALU_MUL_EN is defined.
module tb_hack_alu_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x, y;
  logic        zx, nx, zy, ny, f, no, mul;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic        zr, ng, busy;

  int checks = 0;
  int errors = 0;

  hack_alu_seq #(.WIDTH(16)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y),
    .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
    .mul(mul),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .zr(zr), .ng(ng), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [15:0] xv, input logic [15:0] yv,
                       input logic [5:0] c, input logic m);
    x = xv;
    y = yv;
    {zx, nx, zy, ny, f, no} = c;
    mul = m;
    in_valid = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drive(16'd0, 16'd0, 6'b0, 1'b0);
    in_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
    checks++;
    if ({out, zr, ng, out_valid, busy} !== 20'h0) begin
      errors++;
      $display("FAIL reset_state out=%h zr=%b ng=%b ov=%b busy=%b exp all 0",
               out, zr, ng, out_valid, busy);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b exp 1", in_ready);
    end
  endtask

  task automatic test_add();
    drive(16'd9, 16'd15, 6'b000010, 1'b0);
    step();
    in_valid = 1'b0;
    checks++;
    if ({out, zr, ng, out_valid} !== {16'd24, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL add out=%0d zr=%b ng=%b ov=%b exp 24 0 0 1",
               out, zr, ng, out_valid);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_drain ov=%b exp 0", out_valid);
    end
  endtask

  task automatic test_flags();
    drive(16'd9, 16'd15, 6'b010011, 1'b0);
    step();
    checks++;
    if ({out, zr, ng} !== {16'hFFFA, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL neg out=%h zr=%b ng=%b exp fffa 0 1", out, zr, ng);
    end
    drive(16'd9, 16'd15, 6'b101010, 1'b0);
    step();
    checks++;
    if ({out, zr, ng} !== {16'h0000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL zero out=%h zr=%b ng=%b exp 0000 1 0", out, zr, ng);
    end
    drive(16'h00F0, 16'h0F30, 6'b000000, 1'b0);
    step();
    checks++;
    if (out !== 16'h0030) begin
      errors++;
      $display("FAIL and out=%h exp 0030", out);
    end
    drive(16'h0005, 16'h1234, 6'b001100, 1'b0);
    step();
    in_valid = 1'b0;
    checks++;
    if (out !== 16'h0005) begin
      errors++;
      $display("FAIL and_ones out=%h exp 0005", out);
    end
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      drive(16'(i + 1), 16'd10, 6'b000010, 1'b0);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready[%0d] got %b exp 1", i, in_ready);
      end
      step();
      checks++;
      if ({out, out_valid} !== {16'(11 + i), 1'b1}) begin
        errors++;
        $display("FAIL b2b_out[%0d] out=%0d ov=%b exp %0d 1",
                 i, out, out_valid, 11 + i);
      end
    end
    drive(16'd100, 16'd1, 6'b000010, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_ready[%0d] got %b exp 0", i, in_ready);
      end
      step();
      checks++;
      if ({out, zr, ng, out_valid} !== {16'd14, 1'b0, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL hold_out[%0d] out=%0d ov=%b exp 14 1",
                 i, out, out_valid);
      end
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if ({out, out_valid} !== {16'd101, 1'b1}) begin
      errors++;
      $display("FAIL release out=%0d ov=%b exp 101 1", out, out_valid);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL release_drain ov=%b exp 0", out_valid);
    end
  endtask

`ifdef HACK_ALU_MUL_EN
  task automatic test_mul(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_v);
    int bad;
    bad = 0;
    drive(a, b, 6'b000000, 1'b1);
    step();
    in_valid = 1'b0;
    mul = 1'b0;
    checks++;
    if ({busy, in_ready, out_valid} !== 3'b100) begin
      errors++;
      $display("FAIL mul_start busy=%b rdy=%b ov=%b exp 1 0 0",
               busy, in_ready, out_valid);
    end
    for (int k = 1; k < 16; k++) begin
      step();
      if ({busy, in_ready, out_valid} !== 3'b100) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mul_busy bad_cycles=%0d exp 0", bad);
    end
    step();
    checks++;
    if ({out, out_valid, busy} !== {exp_v, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL mul_result out=%0d ov=%b busy=%b exp %0d 1 0",
               out, out_valid, busy, exp_v);
    end
    step();
  endtask

  task automatic test_mul_reset();
    drive(16'd9, 16'd15, 6'b000000, 1'b1);
    step();
    in_valid = 1'b0;
    mul = 1'b0;
    for (int k = 0; k < 5; k++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({busy, out_valid, out} !== 18'h0) begin
      errors++;
      $display("FAIL mul_abort busy=%b ov=%b out=%h exp 0 0 0000",
               busy, out_valid, out);
    end
    drive(16'd9, 16'd15, 6'b000010, 1'b0);
    step();
    in_valid = 1'b0;
    checks++;
    if ({out, out_valid} !== {16'd24, 1'b1}) begin
      errors++;
      $display("FAIL post_abort out=%0d ov=%b exp 24 1", out, out_valid);
    end
    for (int k = 0; k < 20; k++) step();
    checks++;
    if (out_valid !== 1'b0 || out !== 16'd24) begin
      errors++;
      $display("FAIL abort_no_result out=%0d ov=%b exp 24 0", out, out_valid);
    end
  endtask
`else
  task automatic test_mul_disabled();
    int bad;
    bad = 0;
    drive(16'd9, 16'd15, 6'b000010, 1'b1);
    step();
    in_valid = 1'b0;
    if (busy !== 1'b0) bad++;
    checks++;
    if ({out, out_valid} !== {16'd24, 1'b1}) begin
      errors++;
      $display("FAIL nomul out=%0d ov=%b exp 24 1", out, out_valid);
    end
    for (int k = 0; k < 18; k++) begin
      step();
      if (busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL nomul_busy busy_cycles=%0d exp 0", bad);
    end
    mul = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_flags();
    test_back_to_back();
`ifdef HACK_ALU_MUL_EN
    test_mul(16'd9, 16'd15, 16'd135);
    test_mul(16'd300, 16'd300, 16'd24464);
    test_mul_reset();
`else
    test_mul_disabled();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
